montgomery_exp: RTL and testbench

//   Left-to-right binary modular exponentiation: result = x^e mod m.

---
 rtl/montgomery_exp_pkg.sv | 50 +++++
 rtl/montgomery.sv | 110 +++++++++++
 rtl/montgomery_exp.sv | 249 ++++++++++++++++++++++++
 tb/tb_montgomery_exp.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/montgomery_exp_pkg.sv
// Shared widths, FSM encodings, operand-select codes and the radix-2 Montgomery step
// used by the modular exponentiator and its multiplier.
package montgomery_exp_pkg;

    localparam int N_DEF       = 512;
    localparam int E_WIDTH_DEF = 512;
    // Multiplier operand bits consumed per clock; N_DEF must be a multiple of this.
    localparam int MM_STEP     = 128;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_TOM    = 4'd1,
        ST_TOM_W  = 4'd2,
        ST_SQ     = 4'd3,
        ST_SQ_W   = 4'd4,
        ST_MUL    = 4'd5,
        ST_MUL_W  = 4'd6,
        ST_NXT    = 4'd7,
        ST_FROM   = 4'd8,
        ST_FROM_W = 4'd9,
        ST_DONE   = 4'd10
    } exp_state_e;

    typedef enum logic [1:0] {
        SEL_A   = 2'd0,
        SEL_XM  = 2'd1,
        SEL_R2  = 2'd2,
        SEL_ONE = 2'd3
    } mm_sel_e;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_RUN  = 2'd1,
        MM_FIN  = 2'd2
    } mm_state_e;

    // Add a_bit*b, add m if odd so the sum is even, then halve; stays below 2m.
    function automatic logic [N_DEF+1:0] mont_step(
        input logic [N_DEF+1:0] t,
        input logic             a_bit,
        input logic [N_DEF-1:0] b,
        input logic [N_DEF-1:0] m
    );
        logic [N_DEF+1:0] s;
        s = t + (a_bit ? {2'b00, b} : {(N_DEF+2){1'b0}});
        s = s + (s[0] ? {2'b00, m} : {(N_DEF+2){1'b0}});
        return {1'b0, s[N_DEF+1:1]};
    endfunction

endpackage

// File: rtl/montgomery.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-N mod m, MM_STEP bits of a per clock.
// Operands latched on start; done pulses for one cycle with result held afterwards.
module montgomery
    import montgomery_exp_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int STEP = MM_STEP
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int ITER  = N / STEP;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mm_state_e        state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     result_q, result_d;
    logic [N+1:0]     t_q, t_d, t_step_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Chain of STEP Montgomery steps evaluated in one clock.
    always_comb begin
        t_step_s = t_q;
        for (int i = 0; i < STEP; i++) begin
            t_step_s = mont_step(t_step_s, a_q[i], b_q, m_q);
        end
    end

    // Load on start, iterate over a, then apply the single conditional subtraction.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            MM_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    t_d     = {(N+2){1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = MM_RUN;
                end else begin
                    state_d = MM_IDLE;
                end
            end
            MM_RUN: begin
                t_d   = t_step_s;
                a_d   = a_q >> STEP;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = MM_FIN;
                end else begin
                    state_d = MM_RUN;
                end
            end
            MM_FIN: begin
                result_d = N'((t_q >= {2'b00, m_q}) ? (t_q - {2'b00, m_q}) : t_q);
                done_d   = 1'b1;
                state_d  = MM_IDLE;
            end
            default: begin
                state_d = MM_IDLE;
            end
        endcase
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= MM_IDLE;
            a_q      <= {N{1'b0}};
            b_q      <= {N{1'b0}};
            m_q      <= {N{1'b0}};
            t_q      <= {(N+2){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {N{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: rtl/montgomery_exp.sv
// Left-to-right binary modular exponentiation x^e mod m around one Montgomery multiplier.
// Option: define MONTGOMERY_EXP_SKIP_ZEROS_EN to skip squarings above the leading 1 of e.
module montgomery_exp
    import montgomery_exp_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int E_WIDTH = E_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [N-1:0]       in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [N-1:0]       in_m,
    input  logic [N-1:0]       in_r,
    input  logic [N-1:0]       in_r2,
    output logic               busy,
    output logic [N-1:0]       result,
    output logic               done
);

    localparam int IDX_W = $clog2(E_WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(E_WIDTH - 1);

    exp_state_e         state_q, state_d;
    mm_sel_e            sel_q, sel_d;
    logic [N-1:0]       x_q, x_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic [N-1:0]       m_q, m_d;
    logic [N-1:0]       r_q, r_d;
    logic [N-1:0]       r2_q, r2_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       xm_q, xm_d;
    logic [N-1:0]       result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mm_start_q, mm_start_d;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
    logic               seen_one_q, seen_one_d;
`endif

    logic [N-1:0]       mm_a_s, mm_b_s, mm_result_s;
    logic               mm_done_s;

    // Multiplier operand mux, steered by the registered select issued with mm_start.
    always_comb begin
        mm_a_s = a_q;
        mm_b_s = a_q;
        case (sel_q)
            SEL_A:   mm_b_s = a_q;
            SEL_XM:  mm_b_s = xm_q;
            SEL_R2: begin
                mm_a_s = x_q;
                mm_b_s = r2_q;
            end
            SEL_ONE: mm_b_s = {{(N-1){1'b0}}, 1'b1};
            default: mm_b_s = a_q;
        endcase
    end

    // Exponentiation sequencer: next state, operand capture and output updates.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        x_d        = x_q;
        e_d        = e_q;
        m_d        = m_q;
        r_d        = r_q;
        r2_d       = r2_q;
        a_d        = a_q;
        xm_d       = xm_q;
        result_d   = result_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mm_start_d = 1'b0;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
        seen_one_d = seen_one_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    e_d     = in_e;
                    m_d     = in_m;
                    r_d     = in_r;
                    r2_d    = in_r2;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_TOM;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
                    seen_one_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TOM: begin
                mm_start_d = 1'b1;
                sel_d      = SEL_R2;
                state_d    = ST_TOM_W;
            end
            ST_TOM_W: begin
                if (mm_done_s) begin
                    xm_d    = mm_result_s;
                    a_d     = r_q;
                    state_d = ST_SQ;
                end else begin
                    state_d = ST_TOM_W;
                end
            end
            ST_SQ: begin
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
                // A is still mont(1) above the leading one, so squaring it is a no-op.
                if (!seen_one_q) begin
                    if (e_q[idx_q]) begin
                        seen_one_d = 1'b1;
                        state_d    = ST_MUL;
                    end else if (idx_q == {IDX_W{1'b0}}) begin
                        state_d = ST_FROM;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_SQ;
                    end
                end else begin
                    mm_start_d = 1'b1;
                    sel_d      = SEL_A;
                    state_d    = ST_SQ_W;
                end
`else
                mm_start_d = 1'b1;
                sel_d      = SEL_A;
                state_d    = ST_SQ_W;
`endif
            end
            ST_SQ_W: begin
                if (mm_done_s) begin
                    a_d     = mm_result_s;
                    state_d = e_q[idx_q] ? ST_MUL : ST_NXT;
                end else begin
                    state_d = ST_SQ_W;
                end
            end
            ST_MUL: begin
                mm_start_d = 1'b1;
                sel_d      = SEL_XM;
                state_d    = ST_MUL_W;
            end
            ST_MUL_W: begin
                if (mm_done_s) begin
                    a_d     = mm_result_s;
                    state_d = ST_NXT;
                end else begin
                    state_d = ST_MUL_W;
                end
            end
            ST_NXT: begin
                if (idx_q == {IDX_W{1'b0}}) begin
                    state_d = ST_FROM;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = ST_SQ;
                end
            end
            ST_FROM: begin
                mm_start_d = 1'b1;
                sel_d      = SEL_ONE;
                state_d    = ST_FROM_W;
            end
            ST_FROM_W: begin
                if (mm_done_s) begin
                    result_d = mm_result_s;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_FROM_W;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and operand registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_A;
            x_q        <= {N{1'b0}};
            e_q        <= {E_WIDTH{1'b0}};
            m_q        <= {N{1'b0}};
            r_q        <= {N{1'b0}};
            r2_q       <= {N{1'b0}};
            a_q        <= {N{1'b0}};
            xm_q       <= {N{1'b0}};
            result_q   <= {N{1'b0}};
            idx_q      <= IDX_TOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
            seen_one_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            x_q        <= x_d;
            e_q        <= e_d;
            m_q        <= m_d;
            r_q        <= r_d;
            r2_q       <= r2_d;
            a_q        <= a_d;
            xm_q       <= xm_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mm_start_q <= mm_start_d;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
            seen_one_q <= seen_one_d;
`endif
        end
    end

    montgomery #(
        .N    (N),
        .STEP (MM_STEP)
    ) u_mm (
        .clk    (clk),
        .resetn (resetn),
        .start  (mm_start_q),
        .in_a   (mm_a_s),
        .in_b   (mm_b_s),
        .in_m   (m_q),
        .result (mm_result_s),
        .done   (mm_done_s)
    );

    assign busy   = busy_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_montgomery_exp.sv
// Directed self-checking bench for montgomery_exp: small hand-computed cases mod 13,
// a 512-bit modulus case against a plain square-and-multiply model, abort and back-to-back runs.
module tb_montgomery_exp;

    localparam int N      = 512;
    localparam int EW     = 512;
    localparam int BUDGET = 20000;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [N-1:0]  in_x, in_m, in_r, in_r2, result;
    logic [EW-1:0] in_e;
    logic          busy, done;

    int   n_total = 0;
    int   n_bad   = 0;
    int   mm_cnt  = 0;
    logic last_busy;

    logic [N-1:0]   m_big, r_big, r2_big, x_big, e_big, exp_big, e_t5, ones;
    logic [2*N-1:0] wide_m, wide_r;

    always #5 clk = ~clk;

    montgomery_exp #(.N(N), .E_WIDTH(EW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_x   (in_x),
        .in_e   (in_e),
        .in_m   (in_m),
        .in_r   (in_r),
        .in_r2  (in_r2),
        .busy   (busy),
        .result (result),
        .done   (done)
    );

    always @(negedge clk) begin
        if (dut.mm_start_q === 1'b1) mm_cnt <= mm_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] mod_pow(input logic [N-1:0] b, input logic [N-1:0] e,
                                             input logic [N-1:0] m);
        logic [2*N-1:0] acc, base, mm;
        mm   = {{N{1'b0}}, m};
        acc  = {{(2*N-1){1'b0}}, 1'b1};
        base = {{N{1'b0}}, b} % mm;
        for (int i = 0; i < N; i++) begin
            if (e[i]) acc = (acc * base) % mm;
            base = (base * base) % mm;
        end
        return acc[N-1:0];
    endfunction

    task automatic start_run(input logic [N-1:0] x, input logic [N-1:0] e, input logic [N-1:0] m,
                             input logic [N-1:0] r, input logic [N-1:0] r2);
        @(negedge clk);
        in_x  = x;
        in_e  = e;
        in_m  = m;
        in_r  = r;
        in_r2 = r2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
            last_busy = busy;
        end
    endtask

    task automatic do_run(input string tag, input logic [N-1:0] x, input logic [N-1:0] e,
                          input logic [N-1:0] m, input logic [N-1:0] r, input logic [N-1:0] r2,
                          input logic [N-1:0] exp_res, input int exp_mults);
        int base;
        bit found;
        base = mm_cnt;
        start_run(x, e, m, r, r2);
        wait_done(found);
        check_val({tag, "_done"}, N'(found), N'(1'b1));
        check_val({tag, "_result"}, result, exp_res);
        check_val({tag, "_mults"}, N'(mm_cnt - base), N'(exp_mults));
    endtask

    initial begin
        bit found;
        int base;

        resetn = 1'b0;
        start  = 1'b0;
        in_x   = '0;
        in_e   = '0;
        in_m   = '0;
        in_r   = '0;
        in_r2  = '0;
        last_busy = 1'b0;
        ones   = {N{1'b1}};
        e_t5   = {1'b1, {(N-4){1'b0}}, 3'b101};
        m_big  = {16{32'hDEADBEEF}};
        x_big  = {{(N-32){1'b0}}, 32'h1234_5678};
        e_big  = {{(N-32){1'b0}}, 32'd65537};
        wide_m = {{N{1'b0}}, m_big};
        wide_r = {{(N-1){1'b0}}, 1'b1, {N{1'b0}}} % wide_m;
        r_big  = wide_r[N-1:0];
        wide_r = (wide_r * wide_r) % wide_m;
        r2_big = wide_r[N-1:0];
        exp_big = mod_pow(x_big, e_big, m_big);

        repeat (3) @(negedge clk);
        check_val("rst_busy", N'(busy), N'(1'b0));
        check_val("rst_done", N'(done), N'(1'b0));
        check_val("rst_result", result, {N{1'b0}});
        resetn = 1'b1;

        // 3^5 mod 13 = 9 with R mod 13 = 9, R^2 mod 13 = 3; a second start mid-run is ignored.
        base = mm_cnt;
        start_run(512'd3, 512'd5, 512'd13, 512'd9, 512'd3);
        repeat (40) @(negedge clk);
        check_val("t1_busy_mid", N'(busy), N'(1'b1));
        start_run(512'd5, 512'd7, 512'd13, 512'd9, 512'd3);
        wait_done(found);
        check_val("t1_done", N'(found), N'(1'b1));
        check_val("t1_result", result, 512'd9);
        check_val("t1_busy_before_done", N'(last_busy), N'(1'b1));
        check_val("t1_mults", N'(mm_cnt - base), SKIP ? 512'd6 : 512'd516);
        @(negedge clk);
        check_val("t1_done_pulse", N'(done), N'(1'b0));
        check_val("t1_busy_after", N'(busy), N'(1'b0));
        check_val("t1_result_held", result, 512'd9);

        do_run("t2_e0", 512'd7, 512'd0, 512'd13, 512'd9, 512'd3, 512'd1, SKIP ? 2 : 514);
        do_run("t3_big", x_big, e_big, m_big, r_big, r2_big, exp_big, SKIP ? 20 : 516);

        // Abort during the first MUL_W: e has bit 511 set so the multiply comes right after it.
        base = mm_cnt;
        start_run(512'd3, e_t5, 512'd13, 512'd9, 512'd3);
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (mm_cnt >= base + (SKIP ? 2 : 3)) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t5_reach_mul", N'(found), N'(1'b1));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_val("t5_rst_busy", N'(busy), N'(1'b0));
        check_val("t5_rst_done", N'(done), N'(1'b0));
        check_val("t5_rst_result", result, {N{1'b0}});
        @(negedge clk);
        resetn = 1'b1;
        do_run("t5_rerun", 512'd4, 512'd3, 512'd13, 512'd9, 512'd3, 512'd12, SKIP ? 5 : 516);

        // Back-to-back: 2^1 = 2, then 2^(2^512-1) mod 13 = 2^3 = 8.
        do_run("t6_e1", 512'd2, 512'd1, 512'd13, 512'd9, 512'd3, 512'd2, SKIP ? 3 : 515);
        do_run("t6_ones", 512'd2, ones, 512'd13, 512'd9, 512'd3, 512'd8, SKIP ? 1025 : 1026);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
